// File: rtl/cbus_arbiter.sv
// Round-robin arbiter sharing one CBus request/response port between NUM_REQ cache masters.
// Define CBUS_ARB_FIXED_PRIO_EN to select fixed priority (lowest valid index wins) instead.
module cbus_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0][150:0] ireqs,
  output logic [NUM_REQ-1:0][65:0]  iresps,
  output logic [150:0]              oreq,
  input  logic [65:0]               oresp
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PosW  = IDX_W + 1;

  // Field positions inside the packed cbus_req_t / cbus_resp_t vectors.
  localparam int unsigned ReqValidBit  = 150;
  localparam int unsigned RespReadyBit = 65;
  localparam int unsigned RespLastBit  = 64;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [NUM_REQ-1:0] req_valid;
  logic               cand_found;
  logic [IDX_W-1:0]   cand_idx;
  logic               last_beat;

  always_comb begin
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = ireqs[i][ReqValidBit];
    end
  end

  assign last_beat = oresp[RespReadyBit] & oresp[RespLastBit];

`ifdef CBUS_ARB_FIXED_PRIO_EN
  // Scan downwards so the lowest valid index is the final writer.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        cand_found = 1'b1;
        cand_idx   = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [PosW-1:0]  rr_pos;

  // Offsets scanned from farthest to nearest so the nearest after last_grant wins.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    rr_pos     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      rr_pos = {1'b0, last_grant_q} + PosW'(k);
      if (rr_pos >= PosW'(NUM_REQ)) begin
        rr_pos = rr_pos - PosW'(NUM_REQ);
      end
      if (req_valid[rr_pos[IDX_W-1:0]]) begin
        cand_found = 1'b1;
        cand_idx   = rr_pos[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == StBusy && last_beat) begin
      last_grant_d = index_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    unique case (state_q)
      StIdle: begin
        if (cand_found) begin
          index_d = cand_idx;
          state_d = StBusy;
        end
      end
      StBusy: begin
        // Only ready&&last ends the grant, even if the owner drops valid early.
        if (last_beat) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end

  always_comb begin
    oreq   = '0;
    iresps = '0;
    if (state_q == StBusy) begin
      oreq           = ireqs[index_q];
      iresps[index_q] = oresp;
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed self-checking bench for cbus_arbiter with two requesters (icache 0, dcache 1).
// Inputs change 2 ns after a rising edge; outputs are compared 1 ns later.
module tb_cbus_arbiter;

  logic                clk;
  logic                resetn;
  logic [1:0][150:0]   ireqs;
  logic [1:0][65:0]    iresps;
  logic [150:0]        oreq;
  logic [65:0]         oresp;

  int n_checks;
  int n_errors;

  cbus_arbiter #(
    .NUM_REQ (2)
  ) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .ireqs  (ireqs),
    .iresps (iresps),
    .oreq   (oreq),
    .oresp  (oresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [150:0] got, input logic [150:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {valid, is_write, size, addr, strobe, data, len, burst}
  function automatic logic [150:0] mk_req(input logic wr, input logic [63:0] addr,
                                          input logic [7:0] len, input logic [63:0] data);
    return {1'b1, wr, 3'd3, addr, 8'hff, data, len, 2'b01};
  endfunction

  function automatic logic [65:0] mk_resp(input logic rdy, input logic lst,
                                          input logic [63:0] data);
    return {rdy, lst, data};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [150:0] r0, r1;
  logic [65:0]  rsp;
  logic [150:0] exp_req;

  initial begin
    n_checks = 0;
    n_errors = 0;
    resetn   = 1'b0;
    ireqs    = '0;
    oresp    = '0;

    // Reset state
    step();
    settle();
    check("reset_oreq", oreq, '0);
    check("reset_iresp0", 151'(iresps[0]), '0);
    check("reset_iresp1", 151'(iresps[1]), '0);
    resetn = 1'b1;

    // Single requester 1: 4-beat read
    step();
    r1 = mk_req(1'b0, 64'h8000_0000, 8'd3, 64'h0);
    ireqs[1] = r1;
    settle();
    check("t1_idle_oreq", oreq, '0);
    step();
    settle();
    check("t1_grant_oreq", oreq, r1);
    for (int b = 1; b <= 4; b++) begin
      rsp = mk_resp(1'b1, b == 4, 64'(b * 'h11));
      oresp = rsp;
      settle();
      check($sformatf("t1_beat%0d_iresp1", b), 151'(iresps[1]), 151'(rsp));
      check($sformatf("t1_beat%0d_iresp0", b), 151'(iresps[0]), '0);
      step();
    end
    ireqs[1] = '0;
    oresp    = mk_resp(1'b1, 1'b1, 64'hdead);
    settle();
    check("t1_idle_after_last", oreq, '0);
    check("t1_idle_ready_ignored", 151'(iresps[1]), '0);
    oresp = '0;

    // Simultaneous requests right after reset
    resetn = 1'b0;
    settle();
    resetn = 1'b1;
    step();
    r0 = mk_req(1'b0, 64'h1000, 8'd0, 64'h0);
    r1 = mk_req(1'b0, 64'h2000, 8'd0, 64'h0);
    ireqs[0] = r0;
    ireqs[1] = r1;
    step();
    settle();
    check("t2_first_grant", oreq, r0);
    rsp   = mk_resp(1'b1, 1'b1, 64'haa);
    oresp = rsp;
    settle();
    check("t2_iresp0", 151'(iresps[0]), 151'(rsp));
    check("t2_iresp1_quiet", 151'(iresps[1]), '0);
    step();
    ireqs[0] = '0;
    oresp    = '0;
    settle();
    check("t2_gap_idle", oreq, '0);
    step();
    settle();
    check("t2_second_grant", oreq, r1);
    oresp = mk_resp(1'b1, 1'b1, 64'hbb);
    step();
    ireqs[1] = '0;
    oresp    = '0;

    // Fairness: both continuously valid, single-beat, bridge always completing
    ireqs[0] = r0;
    ireqs[1] = r1;
    oresp    = mk_resp(1'b1, 1'b1, 64'h5);
    settle();
    check("t3_start_idle", oreq, '0);
    for (int k = 0; k < 12; k++) begin
      step();
      settle();
      if (k % 2 == 1) begin
        exp_req = '0;
      end else begin
`ifdef CBUS_ARB_FIXED_PRIO_EN
        exp_req = r0;
`else
        exp_req = ((k / 2) % 2 == 0) ? r0 : r1;
`endif
      end
      check($sformatf("t3_cycle%0d", k), oreq, exp_req);
    end
    ireqs = '0;
    oresp = '0;

    // Burst hold: requester 0 16-beat write, requester 1 arrives at beat 3
    r0 = mk_req(1'b1, 64'h3000, 8'd15, 64'hcafe);
    r1 = mk_req(1'b0, 64'h4000, 8'd0, 64'h0);
    ireqs[0] = r0;
    step();
    settle();
    check("t4_grant0", oreq, r0);
    for (int b = 1; b <= 16; b++) begin
      rsp   = mk_resp(1'b1, b == 16, 64'(b));
      oresp = rsp;
      if (b == 3) ireqs[1] = r1;
      settle();
      if (b == 1 || b == 3 || b == 16) begin
        check($sformatf("t4_beat%0d_oreq", b), oreq, r0);
        check($sformatf("t4_beat%0d_iresp0", b), 151'(iresps[0]), 151'(rsp));
      end
      check($sformatf("t4_beat%0d_iresp1", b), 151'(iresps[1]), '0);
      step();
    end
    ireqs[0] = '0;
    oresp    = '0;
    settle();
    check("t4_gap_idle", oreq, '0);
    step();
    settle();
    check("t4_grant1", oreq, r1);
    oresp = mk_resp(1'b1, 1'b1, 64'h0);
    step();
    ireqs = '0;
    oresp = '0;

    // Async reset during beat 5 of 8
    r0 = mk_req(1'b0, 64'h5000, 8'd7, 64'h0);
    r1 = mk_req(1'b0, 64'h6000, 8'd0, 64'h0);
    ireqs[0] = r0;
    step();
    for (int b = 1; b <= 4; b++) begin
      oresp = mk_resp(1'b1, 1'b0, 64'(b));
      step();
    end
    rsp   = mk_resp(1'b1, 1'b0, 64'h5);
    oresp = rsp;
    settle();
    check("t5_beat5_iresp0", 151'(iresps[0]), 151'(rsp));
    #1;
    resetn = 1'b0;
    #1;
    check("t5_async_oreq", oreq, '0);
    check("t5_async_iresp0", 151'(iresps[0]), '0);
    oresp    = '0;
    ireqs[1] = r1;
    #1;
    resetn = 1'b1;
    step();
    settle();
    check("t5_post_reset_prio0", oreq, r0);
    oresp = mk_resp(1'b1, 1'b1, 64'h0);
    step();
    ireqs = '0;
    oresp = '0;
    step();
    settle();
    check("t5_drained", oreq, '0);

    // Protocol violation: requester 1 drops valid mid-burst
    r1 = mk_req(1'b0, 64'h7000, 8'd3, 64'h0);
    ireqs[1] = r1;
    step();
    settle();
    check("t6_grant1", oreq, r1);
    oresp = mk_resp(1'b1, 1'b0, 64'h1);
    step();
    ireqs[1] = '0;
    ireqs[0] = r0;
    oresp    = '0;
    settle();
    check("t6_valid_dropped", oreq, '0);
    step();
    step();
    rsp   = mk_resp(1'b1, 1'b0, 64'h2);
    oresp = rsp;
    settle();
    check("t6_still_busy_oreq", oreq, '0);
    check("t6_still_routed1", 151'(iresps[1]), 151'(rsp));
    check("t6_iresp0_quiet", 151'(iresps[0]), '0);
    step();
    rsp   = mk_resp(1'b1, 1'b1, 64'h3);
    oresp = rsp;
    settle();
    check("t6_last_routed1", 151'(iresps[1]), 151'(rsp));
    step();
    oresp = '0;
    settle();
    check("t6_idle_after_last", oreq, '0);
    step();
    settle();
    check("t6_grant0_after", oreq, r0);
    ireqs = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cbus_arbiter.md
Name: cbus_arbiter

Overview:
- Shares one cbus_req_t/cbus_resp_t port to the AXI bridge between NUM_REQ cache-side masters, e.g. icache = 0 and dcache = 1.
- Round-robin grant; the grant is held for the whole burst until the beat with last is accepted.
- Sits between the caches and the CBus-to-AXI converter.
- Uses the package types cbus_req_t (151 bits) and cbus_resp_t (66 bits).

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- IDX_W, $clog2(NUM_REQ), width of the grant index; derived, not overridden.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous, active-low reset.
- ireqs  input  NUM_REQ x 151  per-requester cbus_req_t.
- iresps  output  NUM_REQ x 66  per-requester cbus_resp_t.
- oreq  output  151  cbus_req_t toward the AXI bridge.
- oresp  input  66  cbus_resp_t from the AXI bridge.

Behaviour:
- Reset: one clock, reset asynchronous and active-low; all state clears asynchronously on resetn=0.
  - state=IDLE, index=0, last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
  - oreq all zero; every iresps all zero.
- FSM states: IDLE, BUSY.
- IDLE:
  - oreq = '0 and all iresps = '0.
  - Candidate = first i with ireqs[i].valid, scanning last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - If a candidate exists, on the next edge: index <= candidate, state <= BUSY.
  - No valid requests: remain in IDLE.
- BUSY:
  - oreq = ireqs[index], passed through combinationally.
  - iresps[index] = oresp; all other iresps = '0.
  - When oresp.ready && oresp.last: next edge state <= IDLE, last_grant <= index.
  - The IDLE cycle after a transaction is mandatory; no back-to-back grant in the same cycle.
- Latency:
  - valid seen in IDLE -> oreq.valid one cycle later.
  - Last beat -> next grant two cycles after the last-beat cycle: IDLE cycle, then BUSY.
- Requester obligation: hold valid and every request field stable from assertion until ready&&last is returned.
- Granted requester deasserts valid while BUSY (protocol violation):
  - oreq.valid follows it low.
  - The arbiter stays BUSY, routes oresp to index, and leaves only on ready&&last.
  - No deadlock beyond bridge behaviour.
- Non-granted requesters see ready=0, last=0, data=0 throughout and must keep waiting.
- Simultaneous new request and last beat: the new request is evaluated in the following IDLE cycle with the updated last_grant.
- oresp.ready && !oresp.last while BUSY: forwarded; no state change.
- oresp.ready in IDLE: ignored; nothing forwarded.
- Index wrap-around: modulo NUM_REQ; for non-power-of-2 NUM_REQ, indices >= NUM_REQ are never produced.
- Reset mid-burst: the arbiter returns to IDLE immediately. Bridge and requesters are reset by the same resetn, so no response routing survives.

Optional Feature:
- Macro CBUS_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest valid index always wins in IDLE. last_grant is not used and may be optimised away. Everything else is unchanged.
- Undefined (default): round-robin as specified above.

Test Plan:
- Single requester: ireqs[1] read, addr=0x8000_0000, len=MLEN4; bridge returns 4 beats with data 0x11..0x44, last on beat 4.
  - Expected: oreq.valid one cycle after request; iresps[1] receives 4 ready beats with identical data; iresps[0] all zero; IDLE one cycle after last.
- Simultaneous requests after reset: ireqs[0] and ireqs[1] valid in the same cycle.
  - Expected: requester 0 granted first; after its last beat, one IDLE cycle, then requester 1 granted.
  - With CBUS_ARB_FIXED_PRIO_EN and requester 0 re-requesting immediately: requester 0 wins again.
- Fairness: both requesters continuously valid for 6 single-beat (MLEN1) transactions.
  - Expected: grants alternate 0,1,0,1,0,1; oreq.valid pattern is 1,0 repeating (BUSY/IDLE).
- Burst hold: ireqs[0] write burst, len=MLEN16; ireqs[1] raises valid at beat 3.
  - Expected: requester 1 is not granted until after beat 16 (last); iresps[1] stays zero during the burst.
- Async reset mid-burst: resetn=0 between clock edges during beat 5 of 8.
  - Expected: oreq and iresps go to 0 without waiting for a clock edge; after release, requester 0 has top priority.
- Protocol violation: granted requester drops valid mid-burst.
  - Expected: oreq.valid=0 and arbiter stays BUSY; returns to IDLE only after the bridge delivers ready&&last.
